io_bus_responder: RTL

Memory-mapped I/O responder on the external side of the core's I/O bus (`address_out_io`/`data_in_io`/`control_out_io` in, `data_out_io` out). It decodes a fixed address window and services word/byte reads and writes to a scratch register, a status register, a free-running timer and two byte FIFOs (TX toward a peripheral, RX from it). Read data returns with a fixed, pipelined latency. `data_out_io` is zero outside its return cycle, so several responders can be OR-merged onto the core's `data_out_io`.

---
 rtl/io_bus_pkg.sv | 28 ++
 rtl/io_byte_fifo.sv | 65 ++++++
 rtl/io_bus_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// Shared encodings for the I/O bus responder: bus control codes, register
// offsets within the 16-byte window and STATUS bit positions.
package io_bus_pkg;

   typedef enum logic [1:0] {
      IO_CTRL_IDLE       = 2'b00,
      IO_CTRL_READ       = 2'b01,
      IO_CTRL_WRITE      = 2'b10,
      IO_CTRL_WRITE_BYTE = 2'b11
   } io_ctrl_e;

   localparam logic [3:0] REG_SCRATCH = 4'h0;
   localparam logic [3:0] REG_STATUS  = 4'h2;
   localparam logic [3:0] REG_TX_DATA = 4'h4;
   localparam logic [3:0] REG_RX_DATA = 4'h6;
   localparam logic [3:0] REG_TIMER   = 4'h8;

   localparam int ST_TX_OVERFLOW = 15;
   localparam int ST_RX_OVERRUN  = 14;
   localparam int ST_RX_COUNT_LO = 4;
   localparam int ST_TX_FULL     = 3;
   localparam int ST_TX_EMPTY    = 2;
   localparam int ST_RX_FULL     = 1;
   localparam int ST_RX_EMPTY    = 0;

   localparam logic [15:0] RX_EMPTY_DATA = 16'h8000;

endpackage

// File: rtl/io_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; head, empty, full and count are all
// registered so downstream logic sees clean flop outputs.
module io_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     main_clk,
   input  logic                     main_rst_n,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt_nxt;
   logic        do_push, do_pop, empty_nxt;
   logic [7:0]  head_nxt;

   // A pop on an empty FIFO is void; a push on a full FIFO only lands if a pop frees a slot.
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | do_pop);
   assign wr_nxt    = wr_ptr + {{AW{1'b0}}, do_push};
   assign rd_nxt    = rd_ptr + {{AW{1'b0}}, do_pop};
   assign cnt_nxt   = wr_nxt - rd_nxt;
   assign empty_nxt = (cnt_nxt == '0);

   always_comb begin
      head_nxt = 8'h00;
      if (!empty_nxt) begin
         if (do_push && (rd_nxt[AW-1:0] == wr_ptr[AW-1:0]))
            head_nxt = push_data;
         else
            head_nxt = mem[rd_nxt[AW-1:0]];
      end
   end

   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         head   <= 8'h00;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         count  <= cnt_nxt;
         empty  <= empty_nxt;
         full   <= cnt_nxt[AW];
         head   <= head_nxt;
      end
   end

   always_ff @(posedge main_clk) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped responder for a 16-byte I/O window: scratch, status, timer
// and TX/RX byte FIFOs, with a fixed two-cycle read return that is OR-mergeable.
module io_bus_responder
   import io_bus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        main_clk,
   input  logic        main_rst_n,
   input  logic [31:0] address_out_io,
   input  logic [15:0] data_in_io,
   input  logic [1:0]  control_out_io,
   output logic [15:0] data_out_io,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   function automatic logic [3:0] sat_count(input logic [CW-1:0] cnt);
      return (32'(cnt) > 32'd15) ? 4'hF : 4'(cnt);
   endfunction

   io_ctrl_e       ctrl_p0;
   logic           hit_p0, rd_p0, wr_p0, wr_word_p0;
   logic [3:0]     reg_p0;
   logic [15:0]    status_p0, rx_data_p0;

   logic [15:0]    scratch, timer;
   logic           tx_overflow, rx_overrun;
   logic           tx_push, tx_pop, tx_empty, tx_full;
   logic           rx_pop, rx_empty, rx_full;
   logic [7:0]     rx_head;
   logic [CW-1:0]  rx_count, tx_count_unused;

   logic           vld_p1;
   logic [3:0]     reg_p1;
   logic [15:0]    status_p1, timer_p1, rx_data_p1;

   // ---- stage 0: decode of the sampled bus transaction
   assign ctrl_p0    = io_ctrl_e'(control_out_io);
   assign hit_p0     = (address_out_io[31:4] == BASE_ADDR[31:4]);
   assign reg_p0     = {address_out_io[3:1], 1'b0};
   assign rd_p0      = hit_p0 && (ctrl_p0 == IO_CTRL_READ);
   assign wr_p0      = hit_p0 && ((ctrl_p0 == IO_CTRL_WRITE) || (ctrl_p0 == IO_CTRL_WRITE_BYTE));
   assign wr_word_p0 = hit_p0 && (ctrl_p0 == IO_CTRL_WRITE);

   assign tx_push  = wr_p0 && (reg_p0 == REG_TX_DATA);
   assign tx_valid = ~tx_empty;
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_pop   = rd_p0 && (reg_p0 == REG_RX_DATA);

   assign status_p0  = {tx_overflow, rx_overrun, 6'b0, sat_count(rx_count),
                        tx_full, tx_empty, rx_full, rx_empty};
   assign rx_data_p0 = rx_empty ? RX_EMPTY_DATA : {8'h00, rx_head};

   io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .main_clk   (main_clk),
      .main_rst_n (main_rst_n),
      .push       (tx_push),
      .push_data  (data_in_io[7:0]),
      .pop        (tx_pop),
      .head       (tx_byte),
      .empty      (tx_empty),
      .full       (tx_full),
      .count      (tx_count_unused)
   );

   io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .main_clk   (main_clk),
      .main_rst_n (main_rst_n),
      .push       (rx_valid),
      .push_data  (rx_byte),
      .pop        (rx_pop),
      .head       (rx_head),
      .empty      (rx_empty),
      .full       (rx_full),
      .count      (rx_count)
   );

   // Architectural state; a sticky set in the same cycle as its clear wins.
   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         scratch     <= 16'h0000;
         timer       <= 16'h0000;
         tx_overflow <= 1'b0;
         rx_overrun  <= 1'b0;
      end else begin
         timer <= timer + 16'd1;
         if (wr_p0 && (reg_p0 == REG_SCRATCH)) begin
            if (wr_word_p0)
               scratch <= data_in_io;
            else if (address_out_io[0])
               scratch[15:8] <= data_in_io[7:0];
            else
               scratch[7:0] <= data_in_io[7:0];
         end
         if (tx_push && tx_full && !tx_pop)
            tx_overflow <= 1'b1;
         else if (wr_word_p0 && (reg_p0 == REG_STATUS) && data_in_io[ST_TX_OVERFLOW])
            tx_overflow <= 1'b0;
         if (rx_valid && rx_full && !rx_pop)
            rx_overrun <= 1'b1;
         else if (wr_word_p0 && (reg_p0 == REG_STATUS) && data_in_io[ST_RX_OVERRUN])
            rx_overrun <= 1'b0;
      end
   end

   // ---- stage 1: capture offset, STATUS, TIMER and popped RX byte
   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= rd_p0;
   end

   always_ff @(posedge main_clk) begin
      reg_p1     <= reg_p0;
      status_p1  <= status_p0;
      timer_p1   <= timer;
      rx_data_p1 <= rx_data_p0;
   end

   // ---- stage 2: read mux onto the bus, zero outside the return cycle
   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         data_out_io <= 16'h0000;
      end else if (!vld_p1) begin
         data_out_io <= 16'h0000;
      end else begin
         case (reg_p1)
            REG_SCRATCH: data_out_io <= scratch;
            REG_STATUS:  data_out_io <= status_p1;
            REG_RX_DATA: data_out_io <= rx_data_p1;
            REG_TIMER:   data_out_io <= timer_p1;
            default:     data_out_io <= 16'h0000;
         endcase
      end
   end

endmodule
